uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1, LSB first; the receive-direction counterpart of `uart_tx` in the ADC test FPGA. It runs on an oversampling clock at OVERSAMPLE × baud. It synchronises the raw pin, validates the start bit at mid-bit, and samples data and stop bits at bit centres. It presents each received byte with a one-cycle valid pulse, and flags framing errors to the command/control logic.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync2.sv | 30 +++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state type and frame constants
// common to the transmit and receive directions.
package uart_pkg;

    // Receive FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_rx_state_t;

    // Frame format shared with uart_tx: 8N1
    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs. Both stages reset
// to RESET_VAL so that a line that idles at that level does not produce a
// spurious edge when reset is released.
module uart_sync2 #(
    parameter int                 WIDTH     = 1,
    parameter logic [WIDTH-1:0]   RESET_VAL = '1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two back-to-back capture stages; only the second stage is used downstream
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// 8N1 asynchronous serial receiver, LSB first, running on an oversampling
// clock. The start bit is validated at its centre, data and stop bits are
// sampled at bit centres, good bytes are presented with a one-cycle valid
// pulse and a low stop bit raises a one-cycle framing-error pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 uart_rx_clk,
    input  logic                 uart_rx_rst,
    input  logic                 uart_rx_pin,
    output logic [DATA_BITS-1:0] uart_rx_data,
    output logic                 uart_rx_valid,
    output logic                 uart_rx_ferr,
    output logic                 uart_rx_busy
);

    localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Start check lands half a bit after the falling edge seen on w_s;
    // every later sample is a full bit after the previous one.
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic                 w_s;
    uart_rx_state_t       r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_busy;

    uart_sync2 #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .i_clk (uart_rx_clk),
        .i_rst (uart_rx_rst),
        .i_d   (uart_rx_pin),
        .o_q   (w_s)
    );

    // Receive FSM with counters, shift register and registered outputs
    always_ff @(posedge uart_rx_clk or posedge uart_rx_rst) begin
        if (uart_rx_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        if (!w_s) begin
                            r_state <= ST_DATA;
                            r_idx   <= '0;
                        end else begin
                            // Line back high before mid-bit: treat as a glitch
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_s;
                        if (r_idx == IDX_LAST) begin
                            r_state <= ST_STOP;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt <= '0;
                        if (w_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            // Data register keeps the last good byte
                            r_ferr  <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                ST_BREAK: begin
                    // Holding here until the line idles gives one ferr per break
                    if (w_s) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign uart_rx_data  = r_data;
    assign uart_rx_valid = r_valid;
    assign uart_rx_ferr  = r_ferr;
    assign uart_rx_busy  = r_busy;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes the expected pulse (kind,
// data, cycle) before driving each frame; a negedge monitor pops and checks
// whenever valid or ferr is seen.
module tb_uart_rx;

    localparam int BIT_T   = 1600;   // 16 clocks of period 100
    localparam int BIT_FST = 1568;   // -2% bit time
    localparam int BIT_SLW = 1632;   // +2% bit time

    typedef struct {
        bit          is_ferr;
        logic [7:0]  data;
        int unsigned cyc;            // 0 = do not check timing
    } exp_t;

    logic       clk;
    logic       rst;
    logic       pin;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;

    exp_t        sb[$];
    int unsigned cyc;
    int unsigned n_total;
    int unsigned n_pass;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .uart_rx_clk   (clk),
        .uart_rx_rst   (rst),
        .uart_rx_pin   (pin),
        .uart_rx_data  (data),
        .uart_rx_valid (valid),
        .uart_rx_ferr  (ferr),
        .uart_rx_busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Posedge count; a frame started at a negedge with cyc=N has edge 0 at N+1
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    task automatic push(input bit is_ferr, input logic [7:0] d, input int unsigned c);
        exp_t e;
        e.is_ferr = is_ferr;
        e.data    = d;
        e.cyc     = c;
        sb.push_back(e);
    endtask

    task automatic wait_n(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stopv, input int bt);
        pin = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            pin = b[i];
            #(bt);
        end
        pin = stopv;
        #(bt);
    endtask

    // Monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (valid || ferr)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'b0, ferr, valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", {30'b0, ferr, valid}, e.is_ferr ? 32'h2 : 32'h1);
                chk("pulse_data", {24'b0, data}, {24'b0, e.data});
                if (e.cyc != 0) chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        logic [7:0] rb;
        logic [7:0] b0f;
        cyc     = 0;
        n_total = 0;
        n_pass  = 0;
        rst     = 1'b1;
        pin     = 1'b1;
        wait_n(3);
        chk("rst_data",  {24'b0, data}, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);
        chk("rst_ferr",  {31'b0, ferr}, 32'h0);
        chk("rst_busy",  {31'b0, busy}, 32'h0);
        rst = 1'b0;
        wait_n(5);

        // 0xA5 then 0x3C back-to-back at exact baud
        push(1'b0, 8'hA5, cyc + 155);
        send(8'hA5, 1'b1, BIT_T);
        push(1'b0, 8'h3C, cyc + 155);
        send(8'h3C, 1'b1, BIT_T);
        wait_n(4);
        chk("busy_after_good", {31'b0, busy}, 32'h0);

        // 5-cycle low glitch
        pin = 1'b0;
        wait_n(3);
        chk("glitch_busy_hi", {31'b0, busy}, 32'h1);
        wait_n(2);
        pin = 1'b1;
        wait_n(20);
        chk("glitch_busy_lo", {31'b0, busy}, 32'h0);

        // 0x55 with low stop bit: ferr, data holds 0x3C, busy stays high
        push(1'b1, 8'h3C, cyc + 155);
        send(8'h55, 1'b0, BIT_T);
        chk("break_busy_hi", {31'b0, busy}, 32'h1);
        pin = 1'b1;
        wait_n(4);
        chk("break_busy_lo", {31'b0, busy}, 32'h0);
        wait_n(4);
        push(1'b0, 8'h81, cyc + 155);
        send(8'h81, 1'b1, BIT_T);
        wait_n(4);

        // Line held low for 40 bit times: a single ferr
        push(1'b1, 8'h81, cyc + 155);
        pin = 1'b0;
        wait_n(40 * 16);
        pin = 1'b1;
        wait_n(6);
        chk("held_low_busy_lo", {31'b0, busy}, 32'h0);
        push(1'b0, 8'hFF, cyc + 155);
        send(8'hFF, 1'b1, BIT_T);
        wait_n(4);

        // Reset during data bit 4 of 0x0F
        b0f = 8'h0F;
        pin = 1'b0;
        #(BIT_T);
        for (int i = 0; i < 4; i++) begin
            pin = b0f[i];
            #(BIT_T);
        end
        pin = b0f[4];
        wait_n(8);
        chk("midframe_busy", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_data",  {24'b0, data}, 32'h0);
        chk("midrst_valid", {31'b0, valid}, 32'h0);
        chk("midrst_ferr",  {31'b0, ferr}, 32'h0);
        chk("midrst_busy",  {31'b0, busy}, 32'h0);
        wait_n(3);
        pin = 1'b1;
        chk("midrst_busy_held", {31'b0, busy}, 32'h0);
        rst = 1'b0;
        wait_n(40);
        chk("post_rst_busy", {31'b0, busy}, 32'h0);
        chk("post_rst_data", {24'b0, data}, 32'h0);
        push(1'b0, 8'hF0, cyc + 155);
        send(8'hF0, 1'b1, BIT_T);
        wait_n(4);

        // Baud skew: 128 bytes at +2%, 128 bytes at -2%
        for (int i = 0; i < 128; i++) begin
            rb = 8'($urandom_range(0, 255));
            push(1'b0, rb, 0);
            send(rb, 1'b1, BIT_SLW);
        end
        pin = 1'b1;
        #(BIT_T * 2);
        for (int i = 0; i < 128; i++) begin
            rb = 8'($urandom_range(0, 255));
            push(1'b0, rb, 0);
            send(rb, 1'b1, BIT_FST);
        end
        pin = 1'b1;

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'h0);
        wait_n(50);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_uart_rx
